// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared states, opcode/status/error constants for the UART command dispatcher
package uart_cmd_pkg;
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WAIT_TX} state_t;
  typedef enum logic [2:0] {CL_TEST, CL_WRITE, CL_READ, CL_CLEAR, CL_EOP, CL_EADDR, CL_ECSUM} cls_t;
  localparam logic [7:0] OP_TEST    = 8'h41;
  localparam logic [7:0] OP_WRITE   = 8'h57;
  localparam logic [7:0] OP_READ    = 8'h52;
  localparam logic [7:0] OP_CLEAR   = 8'h43;
  localparam logic [7:0] ST_OK      = 8'h4B;
  localparam logic [7:0] ST_RD      = 8'h52;
  localparam logic [7:0] ST_ERR     = 8'h45;
  localparam logic [7:0] ERR_OPCODE = 8'h01;
  localparam logic [7:0] ERR_ADDR   = 8'h02;
  localparam logic [7:0] ERR_CSUM   = 8'h03;
endpackage

// File: rtl/uart_cmd_regfile.sv
// uart_cmd_regfile: NUM_REGS x 8-bit registers with one write port, bulk clear and combinational read
module uart_cmd_regfile #(
  parameter int NUM_REGS = 8,
  localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic          clr,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata,
  output logic [7:0]    reg0
);
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];
  always_comb begin
    regs_d = regs_q;
    if (clr) regs_d = '{default: '0};
    else if (we) regs_d[waddr] = wdata;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  assign rdata = regs_q[raddr];
  assign reg0 = regs_q[0];
endmodule

// File: rtl/uart_cmd_dispatch.sv
// uart_cmd_dispatch: decodes UART RX frames, executes against a register file and triggers a TX response.
// Define UART_CMD_CHECKSUM_EN to require and generate an XOR checksum in the last frame byte.
module uart_cmd_dispatch
  import uart_cmd_pkg::*;
#(
  parameter int DBITS = 8,
  parameter int FRAME_BYTES = 18,
  parameter int NUM_REGS = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [FRAME_BYTES*DBITS-1:0] rx_frame,
  input  logic                         rx_valid,
  input  logic                         tx_busy,
  output logic [FRAME_BYTES*DBITS-1:0] tx_frame,
  output logic                         tx_trigger,
  output logic [7:0]                   led_reg,
  output logic [7:0]                   drop_count,
  output logic                         busy
);
  localparam int FW = FRAME_BYTES * DBITS;
  localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int CB = FRAME_BYTES;
`else
  localparam int CB = 3;
  logic unused_rx;
  assign unused_rx = ^rx_frame[FW-1:CB*DBITS];
`endif
  state_t state_q, state_d;
  cls_t cls_q, cls_d;
  logic [CB*DBITS-1:0] cmd_buf_q, cmd_buf_d;
  logic [FW-1:0] tx_frame_q, tx_frame_d, resp;
  logic [7:0] drop_count_q, drop_count_d, rdata;
  logic [DBITS-1:0] opcode, addr, data;
  logic bad_addr, we, clr;
  assign opcode = cmd_buf_q[0 +: DBITS];
  assign addr = cmd_buf_q[DBITS +: DBITS];
  assign data = cmd_buf_q[2*DBITS +: DBITS];
  assign bad_addr = int'(addr) >= NUM_REGS;
  assign we = state_q == EXEC && cls_q == CL_WRITE;
  assign clr = state_q == EXEC && cls_q == CL_CLEAR;
`ifdef UART_CMD_CHECKSUM_EN
  logic [DBITS-1:0] csum, resp_x;
  always_comb begin
    csum = '0;
    for (int k = 0; k < FRAME_BYTES - 1; k++) csum ^= cmd_buf_q[k*DBITS +: DBITS];
  end
`endif
  uart_cmd_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk(clk), .reset_n(reset_n), .we(we), .clr(clr),
    .waddr(addr[AW-1:0]), .wdata(data), .raddr(addr[AW-1:0]),
    .rdata(rdata), .reg0(led_reg)
  );
  always_comb begin
    resp = '0;
    case (cls_q)
      CL_TEST: for (int k = 0; k < FRAME_BYTES; k++) resp[k*DBITS +: DBITS] = DBITS'(8'h30 + 8'((k + 1) % 10));
      CL_WRITE: resp[3*DBITS-1:0] = {data, addr, ST_OK};
      CL_READ: resp[3*DBITS-1:0] = {rdata, addr, ST_RD};
      CL_CLEAR: resp[3*DBITS-1:0] = {8'h00, 8'h00, ST_OK};
      CL_EOP: resp[3*DBITS-1:0] = {opcode, ERR_OPCODE, ST_ERR};
      CL_EADDR: resp[3*DBITS-1:0] = {addr, ERR_ADDR, ST_ERR};
`ifdef UART_CMD_CHECKSUM_EN
      CL_ECSUM: resp[3*DBITS-1:0] = {csum, ERR_CSUM, ST_ERR};
`endif
      default: resp = '0;
    endcase
`ifdef UART_CMD_CHECKSUM_EN
    resp_x = '0;
    for (int k = 0; k < FRAME_BYTES - 1; k++) resp_x ^= resp[k*DBITS +: DBITS];
    resp[FW-DBITS +: DBITS] = resp_x;
`endif
  end
  always_comb begin
    state_d = state_q;
    cls_d = cls_q;
    cmd_buf_d = cmd_buf_q;
    tx_frame_d = tx_frame_q;
    drop_count_d = (rx_valid && state_q != IDLE && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
    case (state_q)
      IDLE: if (rx_valid) begin
        cmd_buf_d = rx_frame[CB*DBITS-1:0];
        state_d = DECODE;
      end
      DECODE: begin
        cls_d = opcode == OP_TEST ? CL_TEST :
                opcode == OP_WRITE ? (bad_addr ? CL_EADDR : CL_WRITE) :
                opcode == OP_READ ? (bad_addr ? CL_EADDR : CL_READ) :
                opcode == OP_CLEAR ? CL_CLEAR : CL_EOP;
`ifdef UART_CMD_CHECKSUM_EN
        if (csum != cmd_buf_q[FW-DBITS +: DBITS]) cls_d = CL_ECSUM;
`endif
        state_d = EXEC;
      end
      EXEC: begin
        tx_frame_d = resp;
        state_d = WAIT_TX;
      end
      default: if (!tx_busy) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cls_q <= CL_TEST;
      cmd_buf_q <= '0;
      tx_frame_q <= '0;
      drop_count_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      cmd_buf_q <= cmd_buf_d;
      tx_frame_q <= tx_frame_d;
      drop_count_q <= drop_count_d;
    end
  assign tx_trigger = state_q == WAIT_TX && !tx_busy;
  assign tx_frame = tx_frame_q;
  assign drop_count = drop_count_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// tb_uart_cmd_dispatch: directed self-checking bench for uart_cmd_dispatch
module tb_uart_cmd_dispatch;
  localparam int FB = 18;
  localparam int FW = FB * 8;
  logic clk = 0, reset_n = 0, rx_valid = 0, tx_busy = 0;
  logic [FW-1:0] rx_frame = '0, tx_frame, tf;
  logic tx_trigger, busy;
  logic [7:0] led_reg, drop_count;
  int n_chk = 0, n_pass = 0, trig_cnt = 0, lat, t0;
  uart_cmd_dispatch dut (
    .clk(clk), .reset_n(reset_n), .rx_frame(rx_frame), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .tx_frame(tx_frame), .tx_trigger(tx_trigger), .led_reg(led_reg), .drop_count(drop_count), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (tx_trigger) trig_cnt <= trig_cnt + 1;
  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [FW-1:0] cs(input logic [FW-1:0] f);
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0] x;
    x = '0;
    for (int k = 0; k < FB - 1; k++) x ^= f[k*8 +: 8];
    f[FW-8 +: 8] = x;
`endif
    return f;
  endfunction
  function automatic logic [FW-1:0] fr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [FW-1:0] f;
    f = '0;
    f[23:0] = {b2, b1, b0};
    return cs(f);
  endfunction
  task automatic cmd_raw(input logic [FW-1:0] f, output int l);
    @(negedge clk);
    rx_frame = f;
    rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
    l = 1;
    while (!tx_trigger && l < 100) begin
      @(negedge clk);
      l++;
    end
    @(negedge clk);
  endtask
  task automatic run(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                     input logic [FW-1:0] exp);
    cmd_raw(fr(b0, b1, b2), lat);
    chk({tag, "_lat"}, FW'(lat), FW'(3));
    chk(tag, tx_frame, exp);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    string s;
    s = "123456789012345678";
    tf = '0;
    for (int k = 0; k < FB; k++) tf[k*8 +: 8] = s[k];
    tf = cs(tf);
    repeat (3) @(negedge clk);
    chk("rst_frame", tx_frame, '0);
    chk("rst_trig", FW'(tx_trigger), '0);
    chk("rst_busy", FW'(busy), '0);
    chk("rst_drop", FW'(drop_count), '0);
    chk("rst_led", FW'(led_reg), '0);
    reset_n = 1;
    t0 = trig_cnt;
    run("w00", "W", 8'h00, 8'hA5, fr(8'h4B, 8'h00, 8'hA5));
    chk("w00_led", FW'(led_reg), FW'(8'hA5));
    chk("w00_trigs", FW'(trig_cnt - t0), FW'(1));
    run("r00", "R", 8'h00, 8'h00, fr(8'h52, 8'h00, 8'hA5));
    run("w07", "W", 8'h07, 8'h33, fr(8'h4B, 8'h07, 8'h33));
    run("w08", "W", 8'h08, 8'h5A, fr(8'h45, 8'h02, 8'h08));
    run("wff", "W", 8'hFF, 8'h11, fr(8'h45, 8'h02, 8'hFF));
    run("r08", "R", 8'h08, 8'h00, fr(8'h45, 8'h02, 8'h08));
    run("r00b", "R", 8'h00, 8'h00, fr(8'h52, 8'h00, 8'hA5));
    run("r07", "R", 8'h07, 8'h00, fr(8'h52, 8'h07, 8'h33));
    chk("led_keep", FW'(led_reg), FW'(8'hA5));
    run("zop", "Z", 8'h00, 8'h00, fr(8'h45, 8'h01, 8'h5A));
    tx_busy = 1;
    t0 = trig_cnt;
    @(negedge clk);
    rx_frame = fr("A", 8'h00, 8'h00);
    rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
    repeat (5) @(negedge clk);
    rx_frame = fr("W", 8'h01, 8'h77);
    rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
    repeat (14) @(negedge clk);
    chk("hold_trigs", FW'(trig_cnt - t0), '0);
    chk("hold_busy", FW'(busy), FW'(1));
    chk("drop_one", FW'(drop_count), FW'(1));
    tx_busy = 0;
    #1;
    chk("release_trig", FW'(tx_trigger), FW'(1));
    repeat (5) @(negedge clk);
    chk("release_trigs", FW'(trig_cnt - t0), FW'(1));
    chk("test_frame", tx_frame, tf);
    chk("idle_busy", FW'(busy), '0);
    run("r01", "R", 8'h01, 8'h00, fr(8'h52, 8'h01, 8'h00));
    run("clr", "C", 8'h00, 8'h00, fr(8'h4B, 8'h00, 8'h00));
    chk("clr_led", FW'(led_reg), '0);
    run("r07c", "R", 8'h07, 8'h00, fr(8'h52, 8'h07, 8'h00));
`ifdef UART_CMD_CHECKSUM_EN
    tf = fr("W", 8'h01, 8'h77);
    tf[FW-8 +: 8] = tf[FW-8 +: 8] ^ 8'h01;
    cmd_raw(tf, lat);
    chk("csum_bad", tx_frame, fr(8'h45, 8'h03, 8'h21));
    run("csum_r01", "R", 8'h01, 8'h00, fr(8'h52, 8'h01, 8'h00));
`endif
    run("w3c", "W", 8'h00, 8'h3C, fr(8'h4B, 8'h00, 8'h3C));
    tx_busy = 1;
    @(negedge clk);
    rx_frame = fr("A", 8'h00, 8'h00);
    rx_valid = 1;
    @(negedge clk);
    repeat (260) @(negedge clk);
    rx_valid = 0;
    @(negedge clk);
    chk("drop_sat", FW'(drop_count), FW'(8'hFF));
    chk("led_pre_rst", FW'(led_reg), FW'(8'h3C));
    t0 = trig_cnt;
    #2 reset_n = 0;
    #1;
    chk("arst_frame", tx_frame, '0);
    chk("arst_trig", FW'(tx_trigger), '0);
    chk("arst_busy", FW'(busy), '0);
    chk("arst_drop", FW'(drop_count), '0);
    chk("arst_led", FW'(led_reg), '0);
    tx_busy = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (5) @(negedge clk);
    chk("arst_notrig", FW'(trig_cnt - t0), '0);
    run("post_rst", "R", 8'h00, 8'h00, fr(8'h52, 8'h00, 8'h00));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_cmd_dispatch.md
Name: uart_cmd_dispatch

Overview:
- Command stage directly downstream of the UART core (uart_top).
- Consumes each completed RX frame, decodes the opcode in byte 0, and executes against a small 8-bit register file.
- Builds a response frame and pulses the UART core's TX trigger once per accepted command.
- Replaces the ad-hoc decoder task in the board top level; register 0 drives the board LEDs.

Parameters:
- DBITS, 8, bits per frame byte.
- FRAME_BYTES, 18, bytes per RX and TX frame; must be at least 4.
- NUM_REGS, 8, number of 8-bit registers; power of two, at most 256.

Ports:
- clk  in  1  system clock (100 MHz on board).
- reset_n  in  1  asynchronous active-low reset.
- rx_frame  in  FRAME_BYTES*DBITS  received frame; byte k = bits [8k+7:8k]; byte 0 is the opcode.
- rx_valid  in  1  one-cycle pulse: rx_frame holds a new complete frame.
- tx_busy  in  1  UART core is transmitting; a trigger is not accepted while high.
- tx_frame  out  FRAME_BYTES*DBITS  response frame, same byte ordering as rx_frame.
- tx_trigger  out  1  one-cycle pulse to start transmission of tx_frame.
- led_reg  out  8  live value of register 0.
- drop_count  out  8  saturating count of frames dropped while busy.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE; all registers 0; tx_frame 0; tx_trigger 0; drop_count 0; busy 0.
- Reset mid-command aborts the command; no trigger is issued and register writes not yet committed are lost.
- States and transitions:
  - IDLE: on rx_valid, latch rx_frame into cmd_buf, go to DECODE. busy rises the next cycle.
  - DECODE: classify the opcode; check the address against NUM_REGS (addr >= NUM_REGS gives an error). Go to EXEC.
  - EXEC: commit any register write; load tx_frame. Go to WAIT_TX.
  - WAIT_TX: when tx_busy = 0, pulse tx_trigger for exactly one cycle, go to IDLE. Otherwise stay.
- Latency: rx_valid at cycle N gives tx_trigger at N+3 at the earliest (tx_busy low).
- tx_frame holds its value from EXEC until the next EXEC.
- Unfilled response bytes are 0x00.
- Opcodes (ASCII; addr = byte 1, data = byte 2):
  - 'A' test: response bytes 0..17 = "123456789012345678", byte 0 = '1'.
  - 'W' write: reg[addr] <= data; response {'K', addr, data}.
  - 'R' read: response {'R', addr, reg[addr]}.
  - 'C' clear: all registers <= 0; response {'K', 0x00, 0x00}.
  - Unknown opcode: response {'E', 0x01, opcode}.
  - Bad address on 'W' or 'R': response {'E', 0x02, addr}; no write occurs.
- rx_valid in any state other than IDLE (including the cycle tx_trigger fires): the frame is dropped and drop_count increments, saturating at 0xFF.
- Address compare uses the full 8-bit addr byte; no truncation or wrap-around.

Optional Feature:
- Macro: UART_CMD_CHECKSUM_EN.
- Defined: byte FRAME_BYTES-1 must equal the XOR of bytes 0..FRAME_BYTES-2.
  - Mismatch gives response {'E', 0x03, computed_xor}; no register side effect.
  - Every response's last byte is replaced by the XOR of its preceding bytes.
- Undefined: no check; the last byte is ordinary payload.

Decomposition:
- Package uart_cmd_pkg:
  - state enum (IDLE, DECODE, EXEC, WAIT_TX);
  - opcode constants OP_TEST, OP_WRITE, OP_READ, OP_CLEAR;
  - status constants ST_OK 'K', ST_RD 'R', ST_ERR 'E';
  - error codes ERR_OPCODE 0x01, ERR_ADDR 0x02, ERR_CSUM 0x03.
- Sub-module: uart_cmd_regfile, holding NUM_REGS x 8 registers with write port, clear, combinational read, and reg0 output.

Test Plan:
- Reset, then rx_frame byte0='W', byte1=0x00, byte2=0xA5, pulse rx_valid, tx_busy=0 -> tx_trigger exactly 3 cycles later; tx_frame bytes {0x4B,0x00,0xA5,0...}; led_reg=0xA5.
- Then byte0='R', byte1=0x00 -> tx_frame {0x52,0x00,0xA5}.
- byte0='W', byte1=0x08 (NUM_REGS=8) -> tx_frame {0x45,0x02,0x08}; all registers unchanged.
- byte0='Z' -> {0x45,0x01,0x5A}.
- byte0='A' with tx_busy held high 20 cycles -> no trigger while busy; single trigger on the first cycle tx_busy=0; tx_frame byte0=0x31.
- Second rx_valid during WAIT_TX -> drop_count=1, only one trigger.
- Drive 260 drops -> drop_count=0xFF.
- Assert reset_n low during WAIT_TX -> no trigger; outputs 0 immediately.
- With UART_CMD_CHECKSUM_EN, send 'W' with a wrong last byte -> {0x45,0x03,xor}; no write.
